munoc_core_to_axi4l_master_adapter: RTL and testbench
=====================================================

MUNOC_CORE_TO_AXI4L_MASTER_ADAPTER -- requirements
Module: munoc_core_to_axi4l_master_adapter

Interface
REQ-001 SHALL have parameter BW_PLATFORM_ADDR, default 32, address width.
REQ-002 SHALL have parameter BW_NODE_DATA, default 32, data width; wstrb width is BW_NODE_DATA/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0 (0 = timeout disabled), max wait cycles for the B or R response.
REQ-004 SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  sole clock
- rstnn  in  1  asynchronous active-low reset
REQ-005 SHALL have the core-side request ports:
- req_valid  in  1  request offered
- req_ready  out  1  request accepted
- req_write  in  1  1 = write, 0 = read
- req_addr  in  BW_PLATFORM_ADDR  byte address
- req_wdata  in  BW_NODE_DATA  write data
- req_wstrb  in  BW_NODE_DATA/8  byte enables
REQ-006 SHALL have the core-side response ports:
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  BW_NODE_DATA  read data (0 for writes)
- rsp_error  out  1  SLVERR/DECERR/timeout
REQ-007 SHALL have the AXI4-Lite master ports, which drive a network-interface rx4l* port set:
- sx4lawaddr/sx4lawvalid out, sx4lawready in
- sx4lwdata/sx4lwstrb/sx4lwvalid out, sx4lwready in
- sx4lbresp[2] in, sx4lbvalid in, sx4lbready out
- sx4laraddr/sx4larvalid out, sx4larready in
- sx4lrdata in, sx4lrresp[2] in, sx4lrvalid in, sx4lrready out

Function
REQ-008 SHALL use FSM states IDLE, WRITE_REQ, WRITE_RESP, READ_REQ, READ_RESP, CORE_RESP.
REQ-009 SHALL allow at most one outstanding transaction.
REQ-010 SHALL assert req_ready only in IDLE; on acceptance SHALL register addr, wdata and wstrb, then go to WRITE_REQ if req_write=1, otherwise to READ_REQ.
REQ-011 In WRITE_REQ, SHALL assert sx4lawvalid and sx4lwvalid from the cycle after acceptance and drop each independently on its own handshake (aw_done and w_done flags).
REQ-012 SHALL leave WRITE_REQ for WRITE_RESP in the cycle both handshakes are complete, including both completing in the same cycle.
REQ-013 SHALL hold valid and payload stable until ready; a handshake is valid&ready at a rising edge.
REQ-014 SHALL assert sx4lbready only in WRITE_RESP; on a B handshake SHALL set rsp_error = bresp[1], rsp_rdata = 0, and go to CORE_RESP.
REQ-015 SHALL assert sx4larvalid in READ_REQ; on the AR handshake SHALL go to READ_RESP.
REQ-016 SHALL assert sx4lrready only in READ_RESP; on an R handshake SHALL capture rdata, set rsp_error = rresp[1], and go to CORE_RESP.
REQ-017 SHALL assert rsp_valid only in CORE_RESP; on rsp_ready SHALL return to IDLE, with req_ready high the next cycle.
REQ-018 Minimum latency from request acceptance to rsp_valid SHALL be 3 cycles, with zero-wait slave ready/valid.
REQ-019 When TIMEOUT_CYCLES>0, a counter SHALL clear on entering WRITE_RESP or READ_RESP and increment each cycle in those states.
REQ-020 When the counter reaches TIMEOUT_CYCLES, SHALL go to CORE_RESP with rsp_error=1, rsp_rdata=0, and B/R ready deasserted.
REQ-021 A late B or R after a timeout SHALL be ignored: ready stays low and the response is not consumed.
REQ-022 The counter width SHALL be clog2(TIMEOUT_CYCLES+1), minimum 1; it SHALL saturate, never wrap.
REQ-023 sx4lbready and sx4lrready SHALL never be high in the same cycle; any valid on the idle channel SHALL be ignored.

Reset
REQ-024 On rstnn low, SHALL asynchronously set state=IDLE and clear aw_done, w_done and the counter.
REQ-025 On rstnn low, SHALL set all valid/ready outputs to 0 except req_ready, which follows state (1 after release); rsp_rdata=0, rsp_error=0.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no response generated.

Verification
REQ-027 Write 0x1000/0xDEADBEEF/0xF, all ready=1, bresp=0 -> AW and W in the same cycle, rsp_valid 3 cycles after acceptance, rsp_error=0.
REQ-028 Write with awready delayed 4 cycles, wready immediate -> W drops after 1 cycle, AW held 5 cycles with stable addr, single B, one response.
REQ-029 Read 0x2000, rdata=0x12345678, rresp=2 -> rsp_rdata=0x12345678, rsp_error=1.
REQ-030 TIMEOUT_CYCLES=8, no bvalid -> rsp_valid with rsp_error=1 after 8 cycles in WRITE_RESP; later bvalid is not accepted.
REQ-031 rsp_ready held low 5 cycles -> rsp_valid and data held stable, req_ready stays low.
REQ-032 rstnn pulsed low during READ_RESP -> all valids low immediately, req_ready=1 after release, no rsp_valid.

Source files
------------

// File: rtl/munoc_core_to_axi4l_master_adapter.sv
// Purpose : bridges a single-outstanding core request/response port onto an AXI4-Lite master port.
// Latency : 3 cycles from request acceptance to rsp_valid with zero-wait slave; timeout after TIMEOUT_CYCLES in a response state.
// Backpr. : req_ready only in IDLE; AXI valids and rsp_valid hold payload stable until their ready.
//
// Ports:
//   clk, rstnn                   - sole clock, asynchronous active-low reset
//   req_valid/ready/write/addr/wdata/wstrb - core request
//   rsp_valid/ready/rdata/error  - core response (rdata 0 for writes, error on SLVERR/DECERR/timeout)
//   sx4l{aw,w,b,ar,r}*           - AXI4-Lite master channels
module munoc_core_to_axi4l_master_adapter #(
    parameter int BW_PLATFORM_ADDR = 32,
    parameter int BW_NODE_DATA     = 32,
    parameter int TIMEOUT_CYCLES   = 0
) (
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [BW_PLATFORM_ADDR-1:0]   req_addr,
    input  logic [BW_NODE_DATA-1:0]       req_wdata,
    input  logic [BW_NODE_DATA/8-1:0]     req_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [BW_NODE_DATA-1:0]       rsp_rdata,
    output logic                          rsp_error,
    output logic [BW_PLATFORM_ADDR-1:0]   sx4lawaddr,
    output logic                          sx4lawvalid,
    input  logic                          sx4lawready,
    output logic [BW_NODE_DATA-1:0]       sx4lwdata,
    output logic [BW_NODE_DATA/8-1:0]     sx4lwstrb,
    output logic                          sx4lwvalid,
    input  logic                          sx4lwready,
    input  logic [1:0]                    sx4lbresp,
    input  logic                          sx4lbvalid,
    output logic                          sx4lbready,
    output logic [BW_PLATFORM_ADDR-1:0]   sx4laraddr,
    output logic                          sx4larvalid,
    input  logic                          sx4larready,
    input  logic [BW_NODE_DATA-1:0]       sx4lrdata,
    input  logic [1:0]                    sx4lrresp,
    input  logic                          sx4lrvalid,
    output logic                          sx4lrready
);

    localparam int BW_STRB = BW_NODE_DATA / 8;
    localparam int BW_CNT  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [BW_CNT-1:0] CNT_LIMIT = BW_CNT'(TIMEOUT_CYCLES);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WRITE_REQ  = 3'd1;
    localparam logic [2:0] WRITE_RESP = 3'd2;
    localparam logic [2:0] READ_REQ   = 3'd3;
    localparam logic [2:0] READ_RESP  = 3'd4;
    localparam logic [2:0] CORE_RESP  = 3'd5;

    logic [2:0]                  r_state;
    logic [BW_PLATFORM_ADDR-1:0] r_addr;
    logic [BW_NODE_DATA-1:0]     r_wdata;
    logic [BW_STRB-1:0]          r_wstrb;
    logic                        r_aw_done;
    logic                        r_w_done;
    logic [BW_CNT-1:0]           r_cnt;
    logic [BW_NODE_DATA-1:0]     r_rdata;
    logic                        r_error;

    logic                        w_aw_hs;
    logic                        w_w_hs;
    logic [BW_CNT-1:0]           w_cnt_inc;
    logic                        w_timeout;
    logic                        w_unused;

    // Only the upper response bit distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    assign w_unused = sx4lbresp[0] ^ sx4lrresp[0];

    assign req_ready   = (r_state == IDLE);
    assign sx4lawvalid = (r_state == WRITE_REQ) && !r_aw_done;
    assign sx4lwvalid  = (r_state == WRITE_REQ) && !r_w_done;
    assign sx4lawaddr  = r_addr;
    assign sx4lwdata   = r_wdata;
    assign sx4lwstrb   = r_wstrb;
    assign sx4lbready  = (r_state == WRITE_RESP);
    assign sx4larvalid = (r_state == READ_REQ);
    assign sx4laraddr  = r_addr;
    assign sx4lrready  = (r_state == READ_RESP);
    assign rsp_valid   = (r_state == CORE_RESP);
    assign rsp_rdata   = r_rdata;
    assign rsp_error   = r_error;

    assign w_aw_hs = sx4lawvalid && sx4lawready;
    assign w_w_hs  = sx4lwvalid && sx4lwready;

    // Saturating count of cycles spent waiting, including the current one;
    // the timeout fires on the edge where that count hits the limit.
    assign w_cnt_inc = (r_cnt == CNT_LIMIT) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT_CYCLES > 0) && (w_cnt_inc == CNT_LIMIT);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_wstrb   <= req_wstrb;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= req_write ? WRITE_REQ : READ_REQ;
                    end
                end
                WRITE_REQ: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    // Either channel may complete first, or both on the same edge.
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_cnt   <= '0;
                        r_state <= WRITE_RESP;
                    end
                end
                WRITE_RESP: begin
                    r_cnt <= w_cnt_inc;
                    if (sx4lbvalid) begin
                        r_error <= sx4lbresp[1];
                        r_rdata <= '0;
                        r_state <= CORE_RESP;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_rdata <= '0;
                        r_state <= CORE_RESP;
                    end
                end
                READ_REQ: begin
                    if (sx4larready) begin
                        r_cnt   <= '0;
                        r_state <= READ_RESP;
                    end
                end
                READ_RESP: begin
                    r_cnt <= w_cnt_inc;
                    if (sx4lrvalid) begin
                        r_error <= sx4lrresp[1];
                        r_rdata <= sx4lrdata;
                        r_state <= CORE_RESP;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_rdata <= '0;
                        r_state <= CORE_RESP;
                    end
                end
                CORE_RESP: begin
                    if (rsp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_munoc_core_to_axi4l_master_adapter.sv
`timescale 1ns/1ps
module tb_munoc_core_to_axi4l_master_adapter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rstnn;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] sx4lawaddr;  logic sx4lawvalid, sx4lawready;
    logic [31:0] sx4lwdata;   logic [3:0] sx4lwstrb; logic sx4lwvalid, sx4lwready;
    logic [1:0]  sx4lbresp;   logic sx4lbvalid, sx4lbready;
    logic [31:0] sx4laraddr;  logic sx4larvalid, sx4larready;
    logic [31:0] sx4lrdata;   logic [1:0] sx4lrresp; logic sx4lrvalid, sx4lrready;

    munoc_core_to_axi4l_master_adapter #(
        .BW_PLATFORM_ADDR(32), .BW_NODE_DATA(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rstnn(rstnn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .sx4lawaddr(sx4lawaddr), .sx4lawvalid(sx4lawvalid), .sx4lawready(sx4lawready),
        .sx4lwdata(sx4lwdata), .sx4lwstrb(sx4lwstrb), .sx4lwvalid(sx4lwvalid), .sx4lwready(sx4lwready),
        .sx4lbresp(sx4lbresp), .sx4lbvalid(sx4lbvalid), .sx4lbready(sx4lbready),
        .sx4laraddr(sx4laraddr), .sx4larvalid(sx4larvalid), .sx4larready(sx4larready),
        .sx4lrdata(sx4lrdata), .sx4lrresp(sx4lrresp), .sx4lrvalid(sx4lrvalid), .sx4lrready(sx4lrready)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: byte-addressed memory + error region ----------------
    typedef struct { logic [31:0] data; logic err; } exp_t;
    exp_t expq[$];
    logic [31:0] m_mem [int unsigned];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction
    function automatic logic model_err(input logic [31:0] a);
        return a[31:28] == 4'hF;
    endfunction
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return m_mem.exists(a[31:2]) ? m_mem[a[31:2]] : 32'h0;
    endfunction

    // ---------------- AXI4-Lite slave with configurable waits ----------------
    logic [31:0] s_mem [int unsigned];
    int  aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    bit  r_ovr = 0, sl_flush = 0;
    logic [31:0] r_ovr_data = '0;
    logic [1:0]  r_ovr_resp = '0;
    int  n_aw = 0, n_w = 0, n_b = 0, n_r = 0, awv_cyc = 0, wv_cyc = 0, bready_cyc = 0;
    int  aw_hs_cyc = 0, w_hs_cyc = 0;

    function automatic logic [1:0] s_resp(input logic [31:0] a);
        return (a[31:28] == 4'hF) ? (a[27] ? 2'b11 : 2'b10) : 2'b00;
    endfunction

    initial begin
        bit aw_got = 0, w_got = 0, ar_got = 0, b_pend = 0, r_pend = 0, aw_hold = 0, w_hold = 0;
        int aw_c = 0, w_c = 0, ar_c = 0, b_c = 0, r_c = 0;
        logic [31:0] aw_a = '0, w_d = '0, ar_a = '0, hold_a = '0, hold_d = '0, rd_s = '0;
        logic [3:0]  w_s = '0, hold_s = '0;
        logic [1:0]  br_s = '0, rr_s = '0;
        sx4lawready = 0; sx4lwready = 0; sx4lbvalid = 0; sx4lbresp = 0;
        sx4larready = 0; sx4lrvalid = 0; sx4lrresp = 0; sx4lrdata = 0;
        forever begin
            @(negedge clk); #1;
            if (!rstnn || sl_flush) begin
                aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0; aw_hold = 0; w_hold = 0;
                aw_c = 0; w_c = 0; ar_c = 0;
                sx4lawready = 0; sx4lwready = 0; sx4lbvalid = 0; sx4larready = 0; sx4lrvalid = 0;
                sl_flush = 0;
                continue;
            end
            chk("b_r_ready_exclusive", sx4lbready & sx4lrready, 0);
            if (sx4lbready) bready_cyc++;
            // B and R are evaluated before this cycle's AW/W/AR so a response never precedes its request handshake
            if (b_pend) begin
                sx4lbvalid = (b_c >= b_wait); sx4lbresp = br_s;
                if (sx4lbvalid && sx4lbready) begin n_b++; b_pend = 0; end else b_c++;
            end else sx4lbvalid = 0;
            if (r_pend) begin
                sx4lrvalid = (r_c >= r_wait); sx4lrresp = rr_s; sx4lrdata = rd_s;
                if (sx4lrvalid && sx4lrready) begin n_r++; r_pend = 0; end else r_c++;
            end else sx4lrvalid = 0;
            // AW
            if (aw_hold) chk("aw_stable", {sx4lawvalid, sx4lawaddr}, {1'b1, hold_a});
            if (sx4lawvalid) awv_cyc++;
            sx4lawready = sx4lawvalid && !aw_got && (aw_c >= aw_wait);
            aw_hold = sx4lawvalid && !sx4lawready; hold_a = sx4lawaddr;
            if (sx4lawvalid && sx4lawready) begin aw_got = 1; aw_a = sx4lawaddr; aw_c = 0; n_aw++; aw_hs_cyc = cyc; end
            else if (sx4lawvalid) aw_c++;
            // W
            if (w_hold) chk("w_stable", {sx4lwvalid, sx4lwstrb, sx4lwdata}, {1'b1, hold_s, hold_d});
            if (sx4lwvalid) wv_cyc++;
            sx4lwready = sx4lwvalid && !w_got && (w_c >= w_wait);
            w_hold = sx4lwvalid && !sx4lwready; hold_d = sx4lwdata; hold_s = sx4lwstrb;
            if (sx4lwvalid && sx4lwready) begin w_got = 1; w_d = sx4lwdata; w_s = sx4lwstrb; w_c = 0; n_w++; w_hs_cyc = cyc; end
            else if (sx4lwvalid) w_c++;
            // AR
            sx4larready = sx4larvalid && !ar_got && !r_pend && (ar_c >= ar_wait);
            if (sx4larvalid && sx4larready) begin ar_got = 1; ar_a = sx4laraddr; ar_c = 0; end
            else if (sx4larvalid) ar_c++;
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; b_c = 0; br_s = s_resp(aw_a);
                if (br_s == 2'b00)
                    s_mem[aw_a[31:2]] = merge(s_mem.exists(aw_a[31:2]) ? s_mem[aw_a[31:2]] : 32'h0, w_d, w_s);
            end
            if (ar_got) begin
                ar_got = 0; r_pend = 1; r_c = 0;
                rr_s = r_ovr ? r_ovr_resp : s_resp(ar_a);
                rd_s = r_ovr ? r_ovr_data : (s_mem.exists(ar_a[31:2]) ? s_mem[ar_a[31:2]] : 32'h0);
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    int rdy_mode = 1;     // 0 random, 1 always, 2 hold low 5 cycles
    int acc_cyc = 0, last_lat = 0, rv_cyc = 0, n_rsp = 0;

    initial begin
        bit in_rsp = 0, prev_hs = 0;
        int hold_cnt = 0;
        logic [31:0] h_d = '0;
        logic h_e = 0;
        exp_t e;
        rsp_ready = 0;
        forever begin
            @(negedge clk); #1;
            if (!rstnn) begin in_rsp = 0; prev_hs = 0; hold_cnt = 0; rsp_ready = 0; continue; end
            if (prev_hs) chk("req_ready_after_rsp", req_ready, 1);
            prev_hs = 0;
            case (rdy_mode)
                0:       rsp_ready = 1'($urandom_range(0, 1));
                2:       rsp_ready = (hold_cnt >= 5);
                default: rsp_ready = 1;
            endcase
            if (rsp_valid) begin
                rv_cyc++;
                chk("req_ready_low_during_rsp", req_ready, 0);
                if (in_rsp) chk("rsp_stable", {rsp_error, rsp_rdata}, {h_e, h_d});
                else last_lat = cyc - acc_cyc;
                if (rsp_ready) begin
                    if (expq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                    else begin
                        e = expq.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.data);
                        chk("rsp_error", rsp_error, e.err);
                    end
                    n_rsp++; in_rsp = 0; prev_hs = 1; hold_cnt = 0;
                end else begin
                    in_rsp = 1; h_d = rsp_rdata; h_e = rsp_error; hold_cnt++;
                end
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit push, input logic [31:0] e_d, input bit e_e);
        int k = 0;
        @(negedge clk); #1;
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        while (!req_ready && k < 300) begin @(negedge clk); #1; k++; end
        if (!req_ready) chk("req_accept_timeout", req_ready, 1);
        else begin
            acc_cyc = cyc;
            if (push) expq.push_back('{data: e_d, err: e_e});
        end
        @(negedge clk); #1;
        req_valid = 0;
    endtask

    task automatic drain();
        int k = 0;
        while (expq.size() != 0 && k < 400) begin @(negedge clk); k++; end
        if (expq.size() != 0) begin
            chk("rsp_missing", expq.size(), 0);
            expq.delete();
        end
        @(negedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, r0, k;
        rstnn = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        repeat (3) @(negedge clk);
        rstnn = 1;
        @(negedge clk); #2;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_valids", {rsp_valid, sx4lawvalid, sx4lwvalid, sx4larvalid, sx4lbready, sx4lrready}, 6'b0);
        chk("reset_rsp_payload", {rsp_error, rsp_rdata}, 33'h0);

        // zero-wait write, then read it back
        n_b = 0;
        issue(1, 32'h1000, 32'hDEADBEEF, 4'hF, 1, 32'h0, 0);
        drain();
        chk("wr_latency", last_lat, 3);
        chk("aw_w_same_cycle", aw_hs_cyc, w_hs_cyc);
        chk("wr_single_b", n_b, 1);
        issue(0, 32'h1000, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0);
        drain();
        chk("rd_latency", last_lat, 3);

        // awready delayed 4 cycles, wready immediate
        aw_wait = 4; awv_cyc = 0; wv_cyc = 0; n_b = 0; b0 = n_rsp;
        issue(1, 32'h1004, 32'hCAFEF00D, 4'h5, 1, 32'h0, 0);
        drain();
        chk("aw_held_cycles", awv_cyc, 5);
        chk("w_held_cycles", wv_cyc, 1);
        chk("delayed_single_b", n_b, 1);
        chk("delayed_one_rsp", n_rsp - b0, 1);
        aw_wait = 0;

        // read with SLVERR and explicit data
        r_ovr = 1; r_ovr_data = 32'h12345678; r_ovr_resp = 2'b10;
        issue(0, 32'h2000, 32'h0, 4'h0, 1, 32'h12345678, 1);
        drain();
        r_ovr = 0;

        // write timeout, late B must not be consumed
        b_wait = 100; n_b = 0; bready_cyc = 0;
        issue(1, 32'h3000, 32'h11111111, 4'hF, 1, 32'h0, 1);
        drain();
        chk("wr_timeout_latency", last_lat, 10);
        repeat (15) @(negedge clk);
        chk("late_b_ignored", n_b, 0);
        chk("bready_cycles", bready_cyc, TO);
        @(negedge clk); sl_flush = 1; b_wait = 0;
        @(negedge clk);

        // read timeout
        r_wait = 100; r0 = n_r;
        issue(0, 32'h3004, 32'h0, 4'h0, 1, 32'h0, 1);
        drain();
        chk("rd_timeout_latency", last_lat, 10);
        repeat (10) @(negedge clk);
        chk("late_r_ignored", n_r - r0, 0);
        @(negedge clk); sl_flush = 1; r_wait = 0;
        @(negedge clk);

        // core holds rsp_ready low for 5 cycles
        rdy_mode = 2; rv_cyc = 0;
        issue(0, 32'h1000, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0);
        drain();
        chk("rsp_held_cycles", rv_cyc, 6);
        rdy_mode = 1;

        // reset pulse while waiting for R
        r_wait = 100;
        issue(0, 32'h2004, 32'h0, 4'h0, 0, 32'h0, 0);
        k = 0;
        while (!sx4lrready && k < 50) begin @(negedge clk); #2; k++; end
        chk("reached_read_resp", sx4lrready, 1);
        @(negedge clk); #2;
        rstnn = 0; #1;
        chk("reset_mid_valids", {rsp_valid, sx4lawvalid, sx4lwvalid, sx4larvalid, sx4lbready, sx4lrready}, 6'b0);
        repeat (2) @(negedge clk);
        rstnn = 1; r_wait = 0;
        @(negedge clk); #2;
        chk("req_ready_after_reset", req_ready, 1);
        rv_cyc = 0;
        repeat (10) @(negedge clk);
        chk("no_rsp_after_reset", rv_cyc, 0);

        // randomized traffic against the reference model
        rdy_mode = 0;
        for (int i = 0; i < 60; i++) begin
            bit wr;
            logic [31:0] a, d, ed;
            logic [3:0] s;
            logic er;
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                a = 32'hF000_0000 | (32'($urandom_range(0, 1)) << 27) | (32'($urandom_range(0, 3)) << 2);
            else
                a = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            d = $urandom; s = 4'($urandom_range(0, 15));
            aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); ar_wait = $urandom_range(0, 3);
            b_wait = $urandom_range(0, 5);  r_wait = $urandom_range(0, 5);
            er = model_err(a);
            if (wr) begin
                ed = 32'h0;
                if (!er) m_mem[a[31:2]] = merge(model_rd(a), d, s);
            end else ed = model_rd(a);
            issue(wr, a, d, s, 1, ed, er);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
